// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter
//   Streaming 3x3 Sobel edge filter for raster-order CH-channel pixels.
//   Two line buffers per pixel hold the previous rows. A 3x3 window of
//   full pixels slides along the current row. Each channel is filtered
//   independently. Output is either the saturated |Gx|+|Gy| magnitude or a
//   binary edge map, selected per frame.
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-low reset
//   i_mode         0 = magnitude, 1 = threshold (captured on the (0,0) accept)
//   i_thresh       threshold (captured on the (0,0) accept)
//   i_rgb_vld      input pixel valid
//   i_rgb_data     input pixel, channel c at [c*DW +: DW]
//   i_rgb_busy     filter cannot take a pixel this cycle
//   o_result_busy  sink cannot take a result
//   o_result_vld   result valid
//   o_result_data  result pixel, same packing as the input
//   o_frame_done   one-cycle pulse after the last pixel of a frame is accepted
module sobel_stream_filter #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int CH    = 3,
  parameter int DW    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mode,
  input  logic [DW-1:0]    i_thresh,
  input  logic             i_rgb_vld,
  input  logic [CH*DW-1:0] i_rgb_data,
  output logic             i_rgb_busy,
  input  logic             o_result_busy,
  output logic             o_result_vld,
  output logic [CH*DW-1:0] o_result_data,
  output logic             o_frame_done
);
  localparam int PW = CH * DW;
  localparam int MW = DW + 4;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] thresh_q, thresh_d;
  logic [PW-1:0] win_q [3][3];
  logic [PW-1:0] win_d [3][3];
  logic          res_vld_q, res_vld_d;
  logic [PW-1:0] res_data_q, res_data_d;
  logic          done_q, done_d;

  logic [PW-1:0] lb0_mem [IMG_W];
  logic [PW-1:0] lb1_mem [IMG_W];
  logic [PW-1:0] lb0_rd, lb1_rd;
  logic [PW-1:0] sobel_px;
  logic          accept, emit;

  assign i_rgb_busy    = res_vld_q & o_result_busy;
  assign accept        = i_rgb_vld & ~i_rgb_busy;
  // Only a window fully inside the current frame rows/cols produces a result.
  assign emit          = accept && (col_q >= CW'(2)) && (row_q >= RW'(2));
  assign lb0_rd        = lb0_mem[col_q];
  assign lb1_rd        = lb1_mem[col_q];
  assign o_result_vld  = res_vld_q;
  assign o_result_data = res_data_q;
  assign o_frame_done  = done_q;

  // Line buffers: contents need no reset, stale data is never emitted.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1_mem[col_q] <= lb0_rd;
      lb0_mem[col_q] <= i_rgb_data;
    end
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    done_d   = 1'b0;
    win_d    = win_q;
    if (accept) begin
      if (col_q == '0 && row_q == '0) begin
        mode_d   = i_mode;
        thresh_d = i_thresh;
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
      // Shift the window left and load the newest column (row 0 = oldest).
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = i_rgb_data;
    end
  end

  // The result is computed from the window as it will look after this
  // accept, so it can be registered on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [MW-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
      logic [MW-1:0] gx_pos, gx_neg, gy_pos, gy_neg, gx_abs, gy_abs, mag;
      logic [DW-1:0] px_out;

      assign p00 = MW'(win_d[0][0][gi*DW +: DW]);
      assign p01 = MW'(win_d[0][1][gi*DW +: DW]);
      assign p02 = MW'(win_d[0][2][gi*DW +: DW]);
      assign p10 = MW'(win_d[1][0][gi*DW +: DW]);
      assign p12 = MW'(win_d[1][2][gi*DW +: DW]);
      assign p20 = MW'(win_d[2][0][gi*DW +: DW]);
      assign p21 = MW'(win_d[2][1][gi*DW +: DW]);
      assign p22 = MW'(win_d[2][2][gi*DW +: DW]);

      // Absolute differences of the positive and negative kernel halves
      // give |Gx| and |Gy| without signed arithmetic.
      always_comb begin
        gx_pos = p02 + (p12 << 1) + p22;
        gx_neg = p00 + (p10 << 1) + p20;
        gy_pos = p20 + (p21 << 1) + p22;
        gy_neg = p00 + (p01 << 1) + p02;
        gx_abs = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
        gy_abs = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
        mag    = gx_abs + gy_abs;
        if (mode_q) begin
          px_out = (mag >= MW'(thresh_q)) ? '1 : '0;
        end else begin
          px_out = (mag > MW'({DW{1'b1}})) ? '1 : mag[DW-1:0];
        end
      end

      assign sobel_px[gi*DW +: DW] = px_out;
    end
  endgenerate

  // A new result can only arrive when the output slot is free or draining,
  // because accept is blocked while a result is held.
  always_comb begin
    res_vld_d  = res_vld_q;
    res_data_d = res_data_q;
    if (emit) begin
      res_vld_d  = 1'b1;
      res_data_d = sobel_px;
    end else if (!o_result_busy) begin
      res_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= 1'b0;
      thresh_q   <= '0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
      done_q     <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      mode_q     <= mode_d;
      thresh_q   <= thresh_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      done_q     <= done_d;
      win_q      <= win_d;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
module tb_sobel_stream_filter;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int CH  = 3;
  localparam int DW  = 8;
  localparam int NPX = W * H;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_mode = 1'b0;
  logic [7:0]  i_thresh = 8'h00;
  logic        i_rgb_vld = 1'b0;
  logic [23:0] i_rgb_data = 24'h0;
  logic        i_rgb_busy;
  logic        o_result_busy = 1'b0;
  logic        o_result_vld;
  logic [23:0] o_result_data;
  logic        o_frame_done;

  always #5 i_clk = ~i_clk;

  sobel_stream_filter #(.IMG_W(W), .IMG_H(H), .CH(CH), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_thresh(i_thresh),
    .i_rgb_vld(i_rgb_vld), .i_rgb_data(i_rgb_data), .i_rgb_busy(i_rgb_busy),
    .o_result_busy(o_result_busy), .o_result_vld(o_result_vld),
    .o_result_data(o_result_data), .o_frame_done(o_frame_done)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] img [NPX];
  logic [23:0] exp_q [$];
  int          res_cnt = 0;
  int          done_cnt = 0;
  int          full_frames = 0;
  bit          stall_en = 1'b0;
  bit          held = 1'b0;
  logic [23:0] held_data = 24'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: direct 3x3 convolution of the stored image around (r,c).
  function automatic logic [23:0] model_px(int r, int c, bit mode, int thr);
    logic [23:0] out;
    int gx, gy, mag, v;
    out = '0;
    for (int ch = 0; ch < CH; ch++) begin
      gx = 0;
      gy = 0;
      for (int i = -1; i <= 1; i++) begin
        for (int j = -1; j <= 1; j++) begin
          v = int'(img[(r + i) * W + c + j][ch*DW +: DW]);
          gx += j * ((i == 0) ? 2 : 1) * v;
          gy += i * ((j == 0) ? 2 : 1) * v;
        end
      end
      mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
      if (mode) out[ch*DW +: DW] = (mag >= thr) ? 8'hFF : 8'h00;
      else      out[ch*DW +: DW] = (mag > 255) ? 8'hFF : 8'(mag);
    end
    return out;
  endfunction

  // Queue the results owed for the first n accepted pixels of a frame.
  task automatic predict(input int n, input bit mode, input int thr);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        if (r * W + c < n) exp_q.push_back(model_px(r - 1, c - 1, mode, thr));
  endtask

  // Mode/threshold are only meaningful on the first pixel; scrambled after.
  task automatic send_frame(input int n, input bit mode, input logic [7:0] thr);
    int guard;
    bit b;
    for (int k = 0; k < n; k++) begin
      i_rgb_vld  = 1'b1;
      i_rgb_data = img[k];
      i_mode     = (k == 0) ? mode : 1'($urandom);
      i_thresh   = (k == 0) ? thr : 8'($urandom);
      guard = 0;
      forever begin
        @(negedge i_clk);
        b = i_rgb_busy;
        @(posedge i_clk);
        #1;
        if (!b) break;
        guard++;
        if (guard > 500) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: pixel %0d not accepted after %0d cycles", k, guard);
          break;
        end
      end
    end
    i_rgb_vld  = 1'b0;
    i_rgb_data = 24'($urandom);
    if (n == NPX) full_frames++;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    stall_en = 1'b0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    repeat (3) @(posedge i_clk);
    #1;
    check("results_outstanding", exp_q.size(), 0);
  endtask

  // Random sink backpressure.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      o_result_busy = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Compare process: every output transfer against the model queue.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      held = 1'b0;
    end else begin
      check("busy_rule", i_rgb_busy, o_result_vld & o_result_busy);
      if (held) begin
        check("hold_vld", o_result_vld, 1);
        check("hold_data", o_result_data, held_data);
      end
      if (o_result_vld && !o_result_busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %h, no result was due (t=%0t)", o_result_data, $time);
        end else begin
          check("result", o_result_data, exp_q.pop_front());
        end
        res_cnt++;
      end
      held      = o_result_vld && o_result_busy;
      held_data = o_result_data;
      if (o_frame_done) done_cnt++;
    end
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_rgb_busy", i_rgb_busy, 0);
    check("rst_result_vld", o_result_vld, 0);
    check("rst_result_data", o_result_data, 0);
    check("rst_frame_done", o_frame_done, 0);
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // 1: flat frame
    for (int k = 0; k < NPX; k++) img[k] = 24'h404040;
    check("model_flat", model_px(1, 3, 0, 0), 24'h000000);
    predict(NPX, 0, 0);
    send_frame(NPX, 0, 8'h00);
    drain();
    check("flat_result_count", res_cnt, 12);
    check("flat_frame_done", done_cnt, 1);

    // 2: vertical step, rising in ch0, falling in ch2, flat ch1
    for (int k = 0; k < NPX; k++)
      img[k] = ((k % W) < 4) ? 24'hFF4000 : 24'h0040FF;
    check("model_step_c2", model_px(1, 2, 0, 0), 24'h000000);
    check("model_step_c3", model_px(1, 3, 0, 0), 24'hFF00FF);
    check("model_step_c4", model_px(2, 4, 0, 0), 24'hFF00FF);
    check("model_step_c5", model_px(1, 5, 0, 0), 24'h000000);
    predict(NPX, 0, 0);
    send_frame(NPX, 0, 8'h00);
    drain();

    // 3: ramp of 5 per column gives mag = 4*10 = 40 everywhere
    for (int k = 0; k < NPX; k++) img[k] = {3{8'((k % W) * 5)}};
    check("model_ramp_mag", model_px(1, 3, 0, 0), 24'h282828);
    check("model_ramp_t40", model_px(1, 3, 1, 40), 24'hFFFFFF);
    check("model_ramp_t41", model_px(2, 6, 1, 41), 24'h000000);
    predict(NPX, 1, 41);
    send_frame(NPX, 1, 8'd41);
    predict(NPX, 1, 40);
    send_frame(NPX, 1, 8'd40);
    drain();
    check("ramp_last_data", o_result_data, 24'hFFFFFF);

    // 5: reset after 13 accepts of a new frame
    for (int k = 0; k < NPX; k++) img[k] = 24'($urandom);
    predict(13, 0, 0);
    send_frame(13, 1, 8'h10);
    @(negedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    check("midrst_result_vld", o_result_vld, 0);
    check("midrst_result_data", o_result_data, 0);
    check("midrst_rgb_busy", i_rgb_busy, 0);
    check("midrst_frame_done", o_frame_done, 0);
    exp_q.delete();
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    predict(NPX, 0, 0);
    send_frame(NPX, 0, 8'h00);
    drain();

    // 4: random sink backpressure with continuous input
    stall_en = 1'b1;
    for (int k = 0; k < NPX; k++) img[k] = 24'($urandom);
    predict(NPX, 0, 0);
    send_frame(NPX, 0, 8'h00);
    for (int k = 0; k < NPX; k++) img[k] = 24'($urandom);
    predict(NPX, 1, 100);
    send_frame(NPX, 1, 8'd100);
    drain();

    // 6: back-to-back frames toggling mode, light stall
    stall_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NPX; k++) img[k] = 24'($urandom);
      predict(NPX, f[0], 200);
      send_frame(NPX, f[0], 8'd200);
    end
    drain();

    check("total_results", res_cnt, full_frames * (W - 2) * (H - 2));
    check("total_frame_done", done_cnt, full_frames);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
